// File: rtl/seq_mul_wb.sv
// Multi-cycle radix-2 shift-add multiplier with a one-cycle register-file
// write port carrying the full double-width product.
module seq_mul_wb #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             isSigned,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [AW-1:0]    dstAddr,
   output logic             busy,
   output logic             done,
   output logic             RegWrite,
   output logic [AW-1:0]    wrAddr,
   output logic [WIDTH-1:0] wrData,
   output logic [WIDTH-1:0] wrDataExt
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               neg;
   logic [CW-1:0]      cnt;
   logic [AW-1:0]      dst;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] res;
   logic               last;

   // Negating the most negative value wraps to itself, which is the
   // correct unsigned magnitude.
   always_comb begin
      mag_a = (isSigned && opA[WIDTH-1]) ? -opA : opA;
      mag_b = (isSigned && opB[WIDTH-1]) ? -opB : opB;
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      prod  = {sum, lo[WIDTH-1:1]};
      res   = neg ? -prod : prod;
      last  = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      RegWrite = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = FIN;
         end
         FIN: begin
            busy     = 1'b1;
            done     = 1'b1;
            RegWrite = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand     <= '0;
         hi        <= '0;
         lo        <= '0;
         neg       <= 1'b0;
         cnt       <= '0;
         dst       <= '0;
         wrAddr    <= '0;
         wrData    <= '0;
         wrDataExt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand <= mag_a;
                  hi    <= '0;
                  lo    <= mag_b;
                  neg   <= isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                  dst   <= dstAddr;
                  cnt   <= '0;
               end
            end
            RUN: begin
               hi  <= prod[2*WIDTH-1:WIDTH];
               lo  <= prod[WIDTH-1:0];
               cnt <= cnt + 1'b1;
               // Final iteration folds sign correction into the FIN load.
               if (last) begin
                  wrAddr    <= dst;
                  wrData    <= res[WIDTH-1:0];
                  wrDataExt <= res[2*WIDTH-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
